shared_adder_arb: RTL



---
 rtl/shared_adder_arb.sv | 116 +++++++++++
 1 files changed

// File: rtl/shared_adder_arb.sv
// Round-robin share of one WIDTH-bit adder among NREQ requesters; grant T, add T+1, rsp_valid from T+2.
// Requests are refused outside IDLE; a result is held stable in RESP until rsp_ready is sampled high.
module shared_adder_arb #(
   parameter  int WIDTH = 16,
   parameter  int NREQ  = 4,
   localparam int IDW   = (NREQ > 2) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_sum,
   output logic                  rsp_carry,
   output logic                  busy
);

   typedef enum logic [1:0] {S_IDLE, S_ADD, S_RESP} state_t;

   state_t             state_q, state_d;
   logic [IDW-1:0]     ptr_q, ptr_d;
   logic [IDW-1:0]     id_q, id_d;
   logic [WIDTH-1:0]   op_a_q, op_a_d;
   logic [WIDTH-1:0]   op_b_q, op_b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               carry_q, carry_d;

   logic               grant_vld;
   logic [IDW-1:0]     grant_idx;
   logic [IDW:0]       cand;

   // First valid requester at or after ptr, wrapping past NREQ-1 back to 0.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr_q} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NREQ))
            cand = cand - (IDW+1)'(NREQ);
         if (!grant_vld && req_valid[cand[IDW-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = cand[IDW-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      case (state_q)
         S_IDLE: begin
            if (grant_vld) begin
               op_a_d  = req_a[grant_idx*WIDTH +: WIDTH];
               op_b_d  = req_b[grant_idx*WIDTH +: WIDTH];
               id_d    = grant_idx;
               state_d = S_ADD;
            end
         end
         S_ADD: begin
            {carry_d, sum_d} = {1'b0, op_a_q} + {1'b0, op_b_q};
            state_d          = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               // The requester just served drops to lowest priority.
               ptr_d   = (id_q == IDW'(NREQ-1)) ? '0 : id_q + 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      if (rst_n && state_q == S_IDLE && grant_vld)
         req_ready[grant_idx] = 1'b1;
      rsp_valid = (state_q == S_RESP);
      busy      = (state_q != S_IDLE);
   end

   assign rsp_id    = id_q;
   assign rsp_sum   = sum_q;
   assign rsp_carry = carry_q;

endmodule
